// File: rtl/shiftright_multicycle.sv
// rtl/shiftright_multicycle.sv - iterative 32-bit SRL/SRA shifter, one binary stage per cycle
//
// Purpose: right shift by 0..31 for the ALU shift path. The shift amount is
// applied as five stages (16, 8, 4, 2, 1), one per clock, so only one
// 32-bit 2:1 stage mux is needed. Latency is 6 cycles from accepted start
// to result_ready, whatever the shift amount.
//
// Ports:
//   clock          in   1   rising-edge clock
//   reset          in   1   synchronous, active-high
//   start          in   1   request; accepted in IDLE or DONE only
//   data_operand   in  32   value to shift (sampled on accepted start)
//   ctrl_shiftamt  in   5   shift distance (sampled on accepted start)
//   ctrl_arith     in   1   1 = SRA, 0 = SRL (sampled on accepted start)
//   result         out 32   registered result; intermediate while busy
//   result_ready   out  1   one-cycle pulse when result is final
//   busy           out  1   high while a shift is in progress

module shiftright_multicycle (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] data_operand,
    input  logic [4:0]  ctrl_shiftamt,
    input  logic        ctrl_arith,
    output logic [31:0] result,
    output logic        result_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_stage;
    logic [4:0]  r_shamt;
    logic        r_fill;
    logic [31:0] r_result;
    logic        r_ready;
    logic        r_busy;

    logic        w_accept;
    logic        w_ready_nxt;
    logic        w_busy_nxt;
    logic [4:0]  w_dist;
    logic [31:0] w_shifted;

    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // Stage distance is 2^k for stage counter k (4 down to 0).
    assign w_dist = 5'd1 << r_stage;

    // Filling with ones is done by shifting the complement and inverting it
    // back, which keeps the stage a plain logical shift plus one 2:1 mux.
    assign w_shifted = r_fill ? ~((~r_result) >> w_dist) : (r_result >> w_dist);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_SHIFT;
            S_SHIFT: if (r_stage == 3'd0) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = start ? S_SHIFT : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the next state; registered below so the outputs
    // line up with the state they describe and have no input-to-output path.
    always_comb begin
        w_busy_nxt  = 1'b0;
        w_ready_nxt = 1'b0;
        case (w_state_nxt)
            S_SHIFT: w_busy_nxt  = 1'b1;
            S_DONE:  w_ready_nxt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_busy  <= w_busy_nxt;
            r_ready <= w_ready_nxt;
        end
    end

    // Datapath: operand capture on accept, one stage per SHIFT cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            r_result <= 32'h0;
            r_stage  <= 3'd0;
            r_shamt  <= 5'd0;
            r_fill   <= 1'b0;
        end else if (w_accept) begin
            r_result <= data_operand;
            r_shamt  <= ctrl_shiftamt;
            r_fill   <= ctrl_arith & data_operand[31];
            r_stage  <= 3'd4;
        end else if (r_state == S_SHIFT) begin
            if (r_shamt[r_stage]) begin
                r_result <= w_shifted;
            end
            if (r_stage != 3'd0) begin
                r_stage <= r_stage - 3'd1;
            end
        end
    end

    assign result       = r_result;
    assign result_ready = r_ready;
    assign busy         = r_busy;

endmodule

// File: tb/tb_shiftright_multicycle.sv
// tb/tb_shiftright_multicycle.sv - self-checking bench for shiftright_multicycle

module tb_shiftright_multicycle;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] data_operand = 32'h0;
    logic [4:0]  ctrl_shiftamt = 5'd0;
    logic        ctrl_arith = 1'b0;
    logic [31:0] result;
    logic        result_ready;
    logic        busy;

    int checks = 0;
    int errors = 0;

    shiftright_multicycle dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .data_operand  (data_operand),
        .ctrl_shiftamt (ctrl_shiftamt),
        .ctrl_arith    (ctrl_arith),
        .result        (result),
        .result_ready  (result_ready),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    // Reference model: the architectural definition of SRL/SRA.
    function automatic logic [31:0] ref_shift(input logic [31:0] op, input logic [4:0] sh, input logic ar);
        logic signed [31:0] s;
        s = op;
        if (ar) return s >>> sh;
        return op >> sh;
    endfunction

    // Drive a one-cycle start at the current negedge; returns at the next negedge.
    task automatic issue(input logic [31:0] op, input logic [4:0] sh, input logic ar);
        start         = 1'b1;
        data_operand  = op;
        ctrl_shiftamt = sh;
        ctrl_arith    = ar;
        @(negedge clock);
        start         = 1'b0;
        data_operand  = $urandom;
        ctrl_shiftamt = 5'($urandom);
        ctrl_arith    = 1'($urandom);
    endtask

    // Called at the first negedge after the accepting edge (k=1). Counts busy
    // cycles and returns the k at which result_ready is seen (-1 if never),
    // leaving the bench at that negedge.
    task automatic watch(output int lat, output int busy_cnt, output logic [31:0] res);
        lat = -1;
        busy_cnt = 0;
        res = 32'hx;
        for (int k = 1; k <= 12; k++) begin
            if (busy) busy_cnt++;
            if (result_ready) begin
                lat = k;
                res = result;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=%h", result, 32'h0); end
        checks++; if (result_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", result_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_srl_basic;
        int lat, bc;
        logic [31:0] res;
        issue(32'hF000_0000, 5'd4, 1'b0);
        watch(lat, bc, res);
        checks++; if (res !== 32'h0F00_0000) begin errors++; $display("FAIL srl_basic_result got=%h exp=%h", res, 32'h0F00_0000); end
        checks++; if (lat != 6) begin errors++; $display("FAIL srl_basic_latency got=%0d exp=6", lat); end
        checks++; if (bc != 5) begin errors++; $display("FAIL srl_basic_busy_cycles got=%0d exp=5", bc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL srl_basic_busy_in_done got=%b exp=0", busy); end
        @(negedge clock);
        checks++; if (result_ready !== 1'b0) begin errors++; $display("FAIL srl_basic_ready_pulse got=%b exp=0", result_ready); end
        checks++; if (result !== 32'h0F00_0000) begin errors++; $display("FAIL srl_basic_hold got=%h exp=%h", result, 32'h0F00_0000); end
    endtask

    task automatic test_corners;
        logic [31:0] ops [3] = '{32'h8000_0000, 32'h8000_0000, 32'hDEAD_BEEF};
        logic [4:0]  shs [3] = '{5'd31, 5'd31, 5'd0};
        logic        ars [3] = '{1'b1, 1'b0, 1'b1};
        logic [31:0] exps[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'hDEAD_BEEF};
        for (int i = 0; i < 3; i++) begin
            int lat, bc;
            logic [31:0] res;
            issue(ops[i], shs[i], ars[i]);
            watch(lat, bc, res);
            checks++; if (res !== exps[i]) begin errors++; $display("FAIL corner%0d_result got=%h exp=%h", i, res, exps[i]); end
            checks++; if (lat != 6) begin errors++; $display("FAIL corner%0d_latency got=%0d exp=6", i, lat); end
            @(negedge clock);
        end
    endtask

    task automatic test_ignore_start;
        int lat = -1;
        int bc = 0;
        logic [31:0] res = 32'hx;
        issue(32'h1234_5678, 5'd8, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            if (busy) bc++;
            if (result_ready) begin lat = k; res = result; end
            start        = (k <= 5);
            data_operand = $urandom;
            ctrl_shiftamt = 5'($urandom);
            ctrl_arith   = 1'($urandom);
            if (k < 6) @(negedge clock);
        end
        start = 1'b0;
        checks++; if (res !== 32'h0012_3456) begin errors++; $display("FAIL ignore_start_result got=%h exp=%h", res, 32'h0012_3456); end
        checks++; if (lat != 6) begin errors++; $display("FAIL ignore_start_latency got=%0d exp=6", lat); end
        checks++; if (bc != 5) begin errors++; $display("FAIL ignore_start_busy_cycles got=%0d exp=5", bc); end
        @(negedge clock);
        checks++; if (busy !== 1'b0 || result_ready !== 1'b0) begin errors++; $display("FAIL ignore_start_idle got=busy%b/ready%b exp=0/0", busy, result_ready); end
    endtask

    task automatic test_back_to_back;
        int lat, bc;
        logic [31:0] res;
        issue(32'hFF00_0000, 5'd8, 1'b1);
        watch(lat, bc, res);
        checks++; if (res !== 32'hFFFF_0000) begin errors++; $display("FAIL b2b_first_result got=%h exp=%h", res, 32'hFFFF_0000); end
        // Still in DONE: launch the next operation in this cycle.
        issue(32'h7000_0000, 5'd3, 1'b1);
        watch(lat, bc, res);
        checks++; if (res !== 32'h0E00_0000) begin errors++; $display("FAIL b2b_second_result got=%h exp=%h", res, 32'h0E00_0000); end
        checks++; if (lat != 6) begin errors++; $display("FAIL b2b_ready_spacing got=%0d exp=6", lat); end
        checks++; if (bc != 5) begin errors++; $display("FAIL b2b_busy_cycles got=%0d exp=5", bc); end
        @(negedge clock);
    endtask

    task automatic test_reset_mid;
        int lat, bc, seen;
        logic [31:0] res;
        issue(32'hAAAA_5555, 5'd5, 1'b1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_mid_result got=%h exp=0", result); end
        checks++; if (result_ready !== 1'b0) begin errors++; $display("FAIL reset_mid_ready got=%b exp=0", result_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy got=%b exp=0", busy); end
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (result_ready || busy) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL reset_mid_discard got=%0d active cycles exp=0", seen); end
        issue(32'h0000_0100, 5'd8, 1'b0);
        watch(lat, bc, res);
        checks++; if (res !== 32'h0000_0001) begin errors++; $display("FAIL reset_mid_next_result got=%h exp=%h", res, 32'h0000_0001); end
        @(negedge clock);
    endtask

    task automatic test_random;
        for (int n = 0; n < 60; n++) begin
            int lat, bc, gap;
            logic [31:0] res, op, exp;
            logic [4:0]  sh;
            logic        ar;
            op = $urandom;
            sh = 5'($urandom);
            ar = 1'($urandom);
            if (n % 8 == 0) op[31] = 1'b1;
            exp = ref_shift(op, sh, ar);
            issue(op, sh, ar);
            watch(lat, bc, res);
            checks++; if (res !== exp) begin errors++; $display("FAIL rand%0d_result op=%h sh=%0d ar=%b got=%h exp=%h", n, op, sh, ar, res, exp); end
            checks++; if (lat != 6) begin errors++; $display("FAIL rand%0d_latency got=%0d exp=6", n, lat); end
            gap = $urandom_range(1, 4);
            for (int g = 0; g < gap; g++) begin
                @(negedge clock);
                data_operand  = $urandom;
                ctrl_shiftamt = 5'($urandom);
                ctrl_arith    = 1'($urandom);
                checks++; if (result !== exp || result_ready !== 1'b0) begin
                    errors++; $display("FAIL rand%0d_idle_hold got=%h/ready%b exp=%h/ready0", n, result, result_ready, exp);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_srl_basic;
        test_corners;
        test_ignore_start;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
